alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Sequential front/back end for the combinational N-bit ALU (ops 000 add, 001 sub, 010 max, 011 compare-LE, 100 average, 101 square, 110 abs, 111 arithmetic shift right).
- Accepts commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered operands into the ALU, captures its outputs one cycle later, and returns a masked, registered response over a second valid/ready handshake.
- Counts signed-overflow events.

Parameters:
- N, 5, operand/result width in bits (two's complement).
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_a  in  N  operand a.
- cmd_b  in  N  operand b (shift amount for op 111).
- cmd_op  in  3  opcode.
- alu_a  out  N  registered operand to the ALU.
- alu_b  out  N  registered operand to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_result  in  N  ALU result.
- alu_sign  in  1  ALU sign flag.
- alu_overflow  in  1  ALU overflow flag.
- alu_status  in  1  ALU comparison flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  N  captured result.
- rsp_sign  out  1  captured sign.
- rsp_overflow  out  1  overflow, masked.
- rsp_status  out  1  status, masked.
- rsp_op  out  3  opcode of this response.
- ovf_count  out  CNT_W  saturating count of responses with rsp_overflow=1.
- busy  out  1  high when state != IDLE or FIFO is not empty.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO emptied; state becomes IDLE.
  - alu_a, alu_b, alu_op, all rsp_* outputs and ovf_count go to 0.
  - cmd_ready=1 after reset.
  - Reset mid-operation discards any in-flight command and any pending response without emitting it.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready is low when full; there is no same-cycle push-through when full.
  - A push and a pop in the same cycle are both allowed when the FIFO is neither full nor empty, or when it is empty and only a push occurs.
  - Pointers wrap modulo DEPTH; occupancy counter runs 0..DEPTH.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into alu_a/alu_b/alu_op and go to EXEC. Otherwise stay.
  - EXEC (one cycle, lets the ALU settle): at the edge, capture the ALU outputs into rsp_*, set rsp_valid=1 and go to RESP.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready.
    - On handshake with a non-empty FIFO: pop the next command into alu_* and go to EXEC; rsp_valid drops.
    - On handshake with an empty FIFO: rsp_valid=0 and go to IDLE. alu_* retain their last values.
- Latency:
  - Command accepted at edge k into an empty, idle stage gives rsp_valid=1 after edge k+2.
  - Under continuous rsp_ready, throughput is one response per 2 cycles.
- Masking:
  - rsp_overflow = alu_overflow only when op is 000 or 001, else 0.
  - rsp_status = alu_status only when op = 011, else 0.
  - rsp_sign = alu_sign for every op; rsp_result is passed through unmodified.
- ovf_count increments at the EXEC capture edge when the masked overflow is 1, and saturates at all-ones.
- Simultaneous cmd push and rsp handshake in RESP with an empty FIFO: the push lands in the FIFO and is popped on the following IDLE cycle.

Decomposition:
- Shared package alu_pkg holds:
  - localparam opcodes OP_ADD, OP_SUB, OP_MAX, OP_CMP, OP_AVG, OP_SQR, OP_ABS, OP_SHR;
  - FSM state encodings S_IDLE, S_EXEC, S_RESP (2 bits);
  - helper function is_arith(op).
- One sub-module, alu_cmd_fifo, parameterised by width (2N+3) and DEPTH, with push/pop/full/empty ports.
- The FSM, capture registers and counter live in the top module.

Test Plan:
- Single add, N=5: a=11011, b=00011, op=000 -> rsp_valid 2 cycles after acceptance with result 11110, sign 1, overflow 0, status 0, ovf_count stays 0.
- Overflow: a=01111, b=00001, op=000 -> result 10000, overflow 1, ovf_count=1. Then compare a=11100, b=00001, op=011 -> result 00001, status 1, overflow forced 0.
- Masking: op=110 with the ALU model driving overflow=1 and status=1 -> rsp_overflow=0, rsp_status=0.
- Backpressure plus full FIFO:
  - Hold rsp_ready=0 and push 5 commands: cmd_ready drops after the 4th FIFO entry plus the one in flight; the first response is held stable.
  - Release rsp_ready: all 5 responses arrive in order, 2 cycles apart, with rsp_op matching.
- Reset mid-operation: assert rst in the EXEC cycle with 2 commands queued -> next cycle rsp_valid=0, busy=0, cmd_ready=1, ovf_count=0, and no stale response appears afterwards.
- Saturation: with CNT_W=2, issue 5 overflowing subtractions (a=10000, b=00001, op=001) -> ovf_count reads 3 and holds at 3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM states and a
// small opcode classification helper.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MAX = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_AVG = 3'b100;
  localparam logic [2:0] OP_SQR = 3'b101;
  localparam logic [2:0] OP_ABS = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Only add and subtract can produce a meaningful signed overflow.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of W bits, registered storage and pointers,
// occupancy counter 0..DEPTH. Push is ignored when full, pop when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == CW'(0));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_q[rd_ptr_q];

  // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: buffers commands, drives registered operands into an
// external combinational ALU, captures its flags one cycle later and
// returns a masked response. Also keeps a saturating overflow count.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int N     = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_op,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_sign,
  input  logic             alu_overflow,
  input  logic             alu_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic             rsp_sign,
  output logic             rsp_overflow,
  output logic             rsp_status,
  output logic [2:0]       rsp_op,
  output logic [CNT_W-1:0] ovf_count,
  output logic             busy
);

  localparam int FW = 2 * N + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [N-1:0]     alu_a_q, alu_a_d;
  logic [N-1:0]     alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [N-1:0]     rsp_result_q, rsp_result_d;
  logic             rsp_sign_q, rsp_sign_d;
  logic             rsp_overflow_q, rsp_overflow_d;
  logic             rsp_status_q, rsp_status_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic [FW-1:0]    fifo_din_s;
  logic [FW-1:0]    fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [N-1:0]     head_a_s;
  logic [N-1:0]     head_b_s;
  logic [2:0]       head_op_s;
  logic             ovf_masked_s;
  logic             status_masked_s;

  assign cmd_ready   = !fifo_full_s;
  assign fifo_push_s = cmd_valid && !fifo_full_s;
  assign fifo_din_s  = {cmd_a, cmd_b, cmd_op};
  assign {head_a_s, head_b_s, head_op_s} = fifo_dout_s;

  alu_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .din   (fifo_din_s),
    .pop   (fifo_pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Flag masking keyed on the opcode currently presented to the ALU.
  always_comb begin
    ovf_masked_s    = 1'b0;
    status_masked_s = 1'b0;
    if (is_arith(alu_op_q)) begin
      ovf_masked_s = alu_overflow;
    end else begin
      ovf_masked_s = 1'b0;
    end
    if (alu_op_q == OP_CMP) begin
      status_masked_s = alu_status;
    end else begin
      status_masked_s = 1'b0;
    end
  end

  // Issue FSM: pop into ALU operand regs, capture after one settle cycle,
  // hold the response until the consumer takes it.
  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_sign_d     = rsp_sign_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_status_d   = rsp_status_q;
    rsp_op_d       = rsp_op_q;
    ovf_cnt_d      = ovf_cnt_q;
    fifo_pop_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          alu_a_d    = head_a_s;
          alu_b_d    = head_b_s;
          alu_op_d   = head_op_s;
          state_d    = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        rsp_valid_d    = 1'b1;
        rsp_result_d   = alu_result;
        rsp_sign_d     = alu_sign;
        rsp_overflow_d = ovf_masked_s;
        rsp_status_d   = status_masked_s;
        rsp_op_d       = alu_op_q;
        state_d        = S_RESP;
        if (ovf_masked_s && (ovf_cnt_q != CNT_MAX)) begin
          ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end else begin
          ovf_cnt_d = ovf_cnt_q;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            alu_a_d    = head_a_s;
            alu_b_d    = head_b_s;
            alu_op_d   = head_op_s;
            state_d    = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= 3'b000;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_sign_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_status_q   <= 1'b0;
      rsp_op_q       <= 3'b000;
      ovf_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_sign_q     <= rsp_sign_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_status_q   <= rsp_status_d;
      rsp_op_q       <= rsp_op_d;
      ovf_cnt_q      <= ovf_cnt_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_sign     = rsp_sign_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_status   = rsp_status_q;
  assign rsp_op       = rsp_op_q;
  assign ovf_count    = ovf_cnt_q;
  assign busy         = (state_q != S_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. Two instances share stimulus: one with
// the default 8-bit overflow counter, one with a 2-bit counter for saturation.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [4:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;
  logic       rsp_ready;
  logic       force_flags;

  // main instance signals
  logic       cmd_ready;
  logic [4:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_sign, alu_overflow, alu_status;
  logic       rsp_valid, rsp_sign, rsp_overflow, rsp_status;
  logic [4:0] rsp_result;
  logic [2:0] rsp_op;
  logic [7:0] ovf_count;
  logic       busy;

  // saturation instance signals
  logic       s_cmd_ready;
  logic [4:0] s_alu_a, s_alu_b, s_alu_result;
  logic [2:0] s_alu_op;
  logic       s_alu_sign, s_alu_overflow, s_alu_status;
  logic       s_rsp_valid, s_rsp_sign, s_rsp_overflow, s_rsp_status;
  logic [4:0] s_rsp_result;
  logic [2:0] s_rsp_op;
  logic [1:0] s_ovf_count;
  logic       s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: returns {status, overflow, sign, result}.
  function automatic logic [7:0] alu_ref(input logic [4:0] a, input logic [4:0] b,
                                         input logic [2:0] op);
    logic signed [4:0] sa, sb;
    logic [4:0] r;
    logic [5:0] s6;
    logic ov, st;
    sa = a; sb = b; ov = 1'b0; st = 1'b0; r = 5'd0; s6 = 6'd0;
    case (op)
      3'b000: begin r = a + b; ov = (a[4] == b[4]) && (r[4] != a[4]); end
      3'b001: begin r = a - b; ov = (a[4] != b[4]) && (r[4] != a[4]); end
      3'b010: r = (sa > sb) ? a : b;
      3'b011: begin st = (sa <= sb); r = {4'b0000, st}; end
      3'b100: begin s6 = {a[4], a} + {b[4], b}; r = s6[5:1]; end
      3'b101: r = 5'(a * a);
      3'b110: r = a[4] ? 5'(-a) : a;
      default: r = 5'(sa >>> b[2:0]);
    endcase
    return {st, ov, r[4], r};
  endfunction

  logic [7:0] ref_m, ref_s;
  assign ref_m        = alu_ref(alu_a, alu_b, alu_op);
  assign alu_result   = ref_m[4:0];
  assign alu_sign     = ref_m[5];
  assign alu_overflow = ref_m[6] | force_flags;
  assign alu_status   = ref_m[7] | force_flags;
  assign ref_s          = alu_ref(s_alu_a, s_alu_b, s_alu_op);
  assign s_alu_result   = ref_s[4:0];
  assign s_alu_sign     = ref_s[5];
  assign s_alu_overflow = ref_s[6] | force_flags;
  assign s_alu_status   = ref_s[7] | force_flags;

  alu_issue_stage #(.N(5), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_sign(alu_sign),
    .alu_overflow(alu_overflow), .alu_status(alu_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_sign(rsp_sign), .rsp_overflow(rsp_overflow), .rsp_status(rsp_status),
    .rsp_op(rsp_op), .ovf_count(ovf_count), .busy(busy)
  );

  alu_issue_stage #(.N(5), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op),
    .alu_result(s_alu_result), .alu_sign(s_alu_sign),
    .alu_overflow(s_alu_overflow), .alu_status(s_alu_status),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(s_rsp_result),
    .rsp_sign(s_rsp_sign), .rsp_overflow(s_rsp_overflow), .rsp_status(s_rsp_status),
    .rsp_op(s_rsp_op), .ovf_count(s_ovf_count), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until accepted (bounded).
  task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op);
    int n;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask

  // One full transaction with field checks, then accept the response.
  task automatic do_one(input string tag, input logic [4:0] a, input logic [4:0] b,
                        input logic [2:0] op, input logic [4:0] er, input logic es,
                        input logic eo, input logic est);
    send(a, b, op);
    wait_rsp();
    chk({tag, "_result"}, 32'(rsp_result), 32'(er));
    chk({tag, "_sign"}, 32'(rsp_sign), 32'(es));
    chk({tag, "_ovf"}, 32'(rsp_overflow), 32'(eo));
    chk({tag, "_status"}, 32'(rsp_status), 32'(est));
    chk({tag, "_op"}, 32'(rsp_op), 32'(op));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [4:0] bp_res [5];
  logic [2:0] bp_op  [5];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = 5'd0; cmd_b = 5'd0; cmd_op = 3'd0;
    rsp_ready = 1'b0; force_flags = 1'b0;
    bp_res[0] = 5'b00011; bp_op[0] = 3'b000;
    bp_res[1] = 5'b00010; bp_op[1] = 3'b001;
    bp_res[2] = 5'b00100; bp_op[2] = 3'b010;
    bp_res[3] = 5'b00100; bp_op[3] = 3'b100;
    bp_res[4] = 5'b11100; bp_op[4] = 3'b111;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);

    // single add with latency check
    send(5'b11011, 5'b00011, 3'b000);
    chk("lat_k0", 32'(rsp_valid), 32'd0);
    tick();
    chk("lat_k1", 32'(rsp_valid), 32'd0);
    tick();
    chk("lat_k2", 32'(rsp_valid), 32'd1);
    chk("add_result", 32'(rsp_result), 32'b11110);
    chk("add_sign", 32'(rsp_sign), 32'd1);
    chk("add_ovf", 32'(rsp_overflow), 32'd0);
    chk("add_status", 32'(rsp_status), 32'd0);
    chk("add_ovf_count", 32'(ovf_count), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("add_drop_valid", 32'(rsp_valid), 32'd0);
    chk("add_idle_busy", 32'(busy), 32'd0);

    // overflow add, then compare with overflow forced off
    do_one("ovf", 5'b01111, 5'b00001, 3'b000, 5'b10000, 1'b1, 1'b1, 1'b0);
    chk("ovf_count1", 32'(ovf_count), 32'd1);
    do_one("cmp", 5'b11100, 5'b00001, 3'b011, 5'b00001, 1'b0, 1'b0, 1'b1);
    chk("cmp_ovf_count", 32'(ovf_count), 32'd1);

    // masking: ALU flags forced high
    force_flags = 1'b1;
    do_one("abs", 5'b11101, 5'b00000, 3'b110, 5'b00011, 1'b0, 1'b0, 1'b0);
    do_one("cmpf", 5'b00101, 5'b00001, 3'b011, 5'b00000, 1'b0, 1'b0, 1'b1);
    force_flags = 1'b0;
    chk("mask_ovf_count", 32'(ovf_count), 32'd1);

    // backpressure and full FIFO
    send(5'b00001, 5'b00010, 3'b000);
    send(5'b00101, 5'b00011, 3'b001);
    send(5'b11000, 5'b00100, 3'b010);
    send(5'b00110, 5'b00010, 3'b100);
    send(5'b10000, 5'b00010, 3'b111);
    chk("bp_full_ready", 32'(cmd_ready), 32'd0);
    chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
    chk("bp_hold_result", 32'(rsp_result), 32'b00011);
    cmd_a = 5'b01010; cmd_b = 5'b00001; cmd_op = 3'b000; cmd_valid = 1'b1;
    tick(); tick();
    cmd_valid = 1'b0;
    chk("bp_still_full", 32'(cmd_ready), 32'd0);
    chk("bp_still_result", 32'(rsp_result), 32'b00011);
    chk("bp_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", 32'(rsp_result), 32'(bp_res[i]));
      chk("bp_op", 32'(rsp_op), 32'(bp_op[i]));
      tick();
      if (i < 4) begin
        chk("bp_gap", 32'(rsp_valid), 32'd0);
        tick();
        chk("bp_next", 32'(rsp_valid), 32'd1);
      end
    end
    chk("bp_end_valid", 32'(rsp_valid), 32'd0);
    tick(); tick(); tick();
    chk("bp_no_extra", 32'(rsp_valid), 32'd0);
    chk("bp_end_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b0;

    // reset mid-operation with two commands queued
    send(5'b01111, 5'b00001, 3'b000);
    wait_rsp();
    chk("pre_rst_count", 32'(ovf_count), 32'd2);
    send(5'b00001, 5'b00001, 3'b000);
    send(5'b00010, 5'b00001, 3'b000);
    cmd_a = 5'b00011; cmd_b = 5'b00001; cmd_op = 3'b000; cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk("exec_valid", 32'(rsp_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_count", 32'(ovf_count), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;

    // saturation on the 2-bit counter instance
    for (int i = 1; i <= 5; i++) begin
      do_one("sat", 5'b10000, 5'b00001, 3'b001, 5'b01111, 1'b0, 1'b1, 1'b0);
      chk("sat_count8", 32'(ovf_count), 32'(i));
      chk("sat_count2", 32'(s_ovf_count), 32'((i > 3) ? 3 : i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
